multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Main FSM of the multicycle RV32 core. Sequences one shared ALU, one unified memory port and the register file
//  through FETCH/DECODE/EXECUTE/MEM/WB steps. Drives the 2-bit aluop consumed by the ALU-control decoder, plus all
//  mux selects and write strobes. Supports lw, sw, R-type (add/sub/and/or) and beq; anything else traps.
// PARAMETERS
//  CNT_W        32  width of retired-instruction counter instret
//  ILLEGAL_HALT 1   1: TRAP is terminal until reset; 0: TRAP lasts 1 cycle then FETCH
// PORTS
//  clk          in   1  sole clock, rising edge
//  rst_n        in   1  asynchronous active-low reset
//  run          in   1  FETCH may leave/assert strobes only while run=1
//  opcode       in   7  IR[6:0], valid from DECODE onward
//  funct7       in   7  IR[31:25]
//  zero         in   1  ALU zero flag, sampled in BEQ
//  aluop        out  2  00 add, 01 sub (branch compare), 10 R-type decode
//  alu_src_a    out  2  00 PC, 01 oldPC, 10 rs1 (A reg)
//  alu_src_b    out  2  00 rs2 (B reg), 01 imm, 10 const 4
//  result_src   out  2  00 ALUOut reg, 01 mem data reg, 10 ALU result
//  adr_src      out  1  0 PC, 1 result bus
//  ir_write     out  1  latch IR and oldPC
//  mem_write    out  1  memory write strobe
//  reg_write    out  1  register-file write strobe
//  pc_write     out  1  = pc_update | (branch & zero)
//  illegal      out  1  high while in TRAP
//  instret      out  CNT_W  retired-instruction count
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=FETCH, instret=0. While run=0 or in reset, all strobes (ir_write,mem_write,
//    reg_write,pc_write,illegal) are 0 and all selects are 00.
//  - Outputs are a function of state only, except FETCH gating by run and pc_write in BEQ via zero.
//    Unlisted outputs are 0.
//  - FETCH   (run=1): adr_src=0, ir_write=1, a=00, b=10, aluop=00, result_src=10, pc_update -> DECODE.
//             run=0: remain in FETCH, no strobes.
//  - DECODE : a=01, b=01, aluop=00 (branch target into ALUOut). Next by opcode:
//             0000011 or 0100011 -> MEMADR; 0110011 & funct7 in {0000000,0100000} -> EXECR;
//             1100011 -> BEQ; else -> TRAP.
//  - MEMADR : a=10, b=01, aluop=00 -> MEMRD (lw) or MEMWR (sw).
//  - MEMRD  : result_src=00, adr_src=1 -> MEMWB.
//  - MEMWB  : result_src=01, reg_write=1 -> FETCH.
//  - MEMWR  : result_src=00, adr_src=1, mem_write=1 -> FETCH.
//  - EXECR  : a=10, b=00, aluop=10 -> ALUWB.
//  - ALUWB  : result_src=00, reg_write=1 -> FETCH.
//  - BEQ    : a=10, b=00, aluop=01, result_src=00, branch=1; pc_write=zero -> FETCH.
//  - TRAP   : illegal=1, no write strobes; ILLEGAL_HALT=1 holds, else -> FETCH. instret unchanged.
//  - Latency (run=1): lw 5, sw 4, R-type 4, beq 3 cycles.
//  - instret increments on the cycle leaving MEMWB/MEMWR/ALUWB/BEQ, mod 2^CNT_W (wraps all-ones -> 0).
//  - run only gates FETCH; an instruction in flight completes even if run drops.
//  - rst_n low in any state: immediate return to FETCH, strobes drop combinationally with reset.
//  - Unused state encodings -> FETCH next cycle, no strobes.
// CONFIGURATION
//  MULTICYCLE_CONTROL_MEM_WAIT_EN defined: adds input mem_ready (1 bit). FETCH, MEMRD and MEMWR hold,
//  with all strobes of that state kept asserted, until mem_ready=1. Transition and instret update occur
//  only in the mem_ready=1 cycle. Not defined: port absent, memory is single-cycle (mem_ready==1).
// TESTING
//  1. Reset mid-MEMRD, run=1: rst_n low -> state FETCH, instret=0, no mem_write/reg_write.
//  2. lw (opcode 0000011): states F,D,MA,MR,MW in 5 cycles; reg_write only in cycle 5 with result_src=01;
//     instret 0->1.
//  3. R-type sub (funct7 0100000): EXECR aluop=10, a=10, b=00; ALUWB reg_write=1. funct7 0000001 -> TRAP,
//     illegal=1.
//  4. beq: zero=1 -> pc_write=1 in BEQ; zero=0 -> pc_write=0; aluop=01 in both; instret +1 each.
//  5. CNT_W=4, 16 sw instructions -> instret wraps 15->0; mem_write pulses exactly 16 times.
//  6. MEM_WAIT_EN, mem_ready low 3 cycles in MEMWR -> mem_write held 4 cycles, one instret increment.
//     Also: opcode 1111111 with ILLEGAL_HALT=0 -> TRAP 1 cycle then FETCH.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control/status bundle between the multicycle RV32 datapath and its main FSM.
// MULTICYCLE_CONTROL_MEM_WAIT_EN adds the mem_ready handshake input.
interface multicycle_control_if #(
    parameter int unsigned CNT_W = 32
);
    logic             run;
    logic [6:0]       opcode;
    logic [6:0]       funct7;
    logic             zero;
`ifdef MULTICYCLE_CONTROL_MEM_WAIT_EN
    logic             mem_ready;
`endif
    logic [1:0]       aluop;
    logic [1:0]       alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       result_src;
    logic             adr_src;
    logic             ir_write;
    logic             mem_write;
    logic             reg_write;
    logic             pc_write;
    logic             illegal;
    logic [CNT_W-1:0] instret;

    modport slave (
`ifdef MULTICYCLE_CONTROL_MEM_WAIT_EN
        input  mem_ready,
`endif
        input  run, opcode, funct7, zero,
        output aluop, alu_src_a, alu_src_b, result_src, adr_src,
        output ir_write, mem_write, reg_write, pc_write, illegal, instret
    );

    modport master (
`ifdef MULTICYCLE_CONTROL_MEM_WAIT_EN
        output mem_ready,
`endif
        output run, opcode, funct7, zero,
        input  aluop, alu_src_a, alu_src_b, result_src, adr_src,
        input  ir_write, mem_write, reg_write, pc_write, illegal, instret
    );
endinterface

// File: rtl/multicycle_control.sv
// Main FSM of the multicycle RV32 core: lw, sw, R-type add/sub/and/or, beq; all else traps.
// MULTICYCLE_CONTROL_MEM_WAIT_EN: FETCH/MEMRD/MEMWR stall on mem_ready with their strobes held.
module multicycle_control #(
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned ILLEGAL_HALT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.slave  bus
);
    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExecR  = 4'd6,
        StAluWb  = 4'd7,
        StBeq    = 4'd8,
        StTrap   = 4'd9
    } state_e;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpBranch = 7'b1100011;

    state_e           r_state;
    state_e           w_state_d;
    logic [CNT_W-1:0] r_instret;
    logic             w_retire;
    logic             w_mem_ready;
    logic             w_pc_update;
    logic             w_branch;
    logic [1:0]       w_aluop;
    logic [1:0]       w_alu_src_a;
    logic [1:0]       w_alu_src_b;
    logic [1:0]       w_result_src;
    logic             w_adr_src;
    logic             w_ir_write;
    logic             w_mem_write;
    logic             w_reg_write;
    logic             w_pc_write;
    logic             w_illegal;

`ifdef MULTICYCLE_CONTROL_MEM_WAIT_EN
    assign w_mem_ready = bus.mem_ready;
`else
    assign w_mem_ready = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StFetch;
            r_instret <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_retire) begin
                r_instret <= r_instret + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_retire     = 1'b0;
        w_pc_update  = 1'b0;
        w_branch     = 1'b0;
        w_aluop      = 2'b00;
        w_alu_src_a  = 2'b00;
        w_alu_src_b  = 2'b00;
        w_result_src = 2'b00;
        w_adr_src    = 1'b0;
        w_ir_write   = 1'b0;
        w_mem_write  = 1'b0;
        w_reg_write  = 1'b0;
        w_illegal    = 1'b0;
        case (r_state)
            StFetch: begin
                if (bus.run) begin
                    w_ir_write   = 1'b1;
                    w_alu_src_b  = 2'b10;
                    w_result_src = 2'b10;
                    w_pc_update  = 1'b1;
                    if (w_mem_ready) w_state_d = StDecode;
                end
            end
            StDecode: begin
                // Branch target is computed here so BEQ can reuse the ALU for the compare.
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b01;
                if (bus.opcode == OpLoad || bus.opcode == OpStore) begin
                    w_state_d = StMemAdr;
                end else if (bus.opcode == OpRType &&
                             (bus.funct7 == 7'b0000000 || bus.funct7 == 7'b0100000)) begin
                    w_state_d = StExecR;
                end else if (bus.opcode == OpBranch) begin
                    w_state_d = StBeq;
                end else begin
                    w_state_d = StTrap;
                end
            end
            StMemAdr: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
                w_state_d   = (bus.opcode == OpLoad) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                w_adr_src = 1'b1;
                if (w_mem_ready) w_state_d = StMemWb;
            end
            StMemWb: begin
                w_result_src = 2'b01;
                w_reg_write  = 1'b1;
                w_retire     = 1'b1;
                w_state_d    = StFetch;
            end
            StMemWr: begin
                w_adr_src   = 1'b1;
                w_mem_write = 1'b1;
                if (w_mem_ready) begin
                    w_retire  = 1'b1;
                    w_state_d = StFetch;
                end
            end
            StExecR: begin
                w_alu_src_a = 2'b10;
                w_aluop     = 2'b10;
                w_state_d   = StAluWb;
            end
            StAluWb: begin
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
                w_state_d   = StFetch;
            end
            StBeq: begin
                w_alu_src_a = 2'b10;
                w_aluop     = 2'b01;
                w_branch    = 1'b1;
                w_retire    = 1'b1;
                w_state_d   = StFetch;
            end
            StTrap: begin
                w_illegal = 1'b1;
                if (ILLEGAL_HALT == 0) w_state_d = StFetch;
            end
            default: w_state_d = StFetch;
        endcase

        w_pc_write = w_pc_update | (w_branch & bus.zero);

        // Strobes must drop with rst_n itself, not one edge later.
        if (!rst_n) begin
            w_aluop      = 2'b00;
            w_alu_src_a  = 2'b00;
            w_alu_src_b  = 2'b00;
            w_result_src = 2'b00;
            w_adr_src    = 1'b0;
            w_ir_write   = 1'b0;
            w_mem_write  = 1'b0;
            w_reg_write  = 1'b0;
            w_pc_write   = 1'b0;
            w_illegal    = 1'b0;
        end
    end

    assign bus.aluop      = w_aluop;
    assign bus.alu_src_a  = w_alu_src_a;
    assign bus.alu_src_b  = w_alu_src_b;
    assign bus.result_src = w_result_src;
    assign bus.adr_src    = w_adr_src;
    assign bus.ir_write   = w_ir_write;
    assign bus.mem_write  = w_mem_write;
    assign bus.reg_write  = w_reg_write;
    assign bus.pc_write   = w_pc_write;
    assign bus.illegal    = w_illegal;
    assign bus.instret    = r_instret;
endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: two instances (CNT_W=4 halting trap, CNT_W=32 one-cycle trap)
// share stimulus; a per-instruction-class model gives latency, strobe counts and instret.
module tb_multicycle_control;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic [6:0] opcode;
    logic [6:0] funct7;
    logic       zero;
    logic       mem_ready;
    int         checks = 0;
    int         errors = 0;
    int         exp_ret = 0;
    int         total_mem = 0;

    always #5 clk = ~clk;

    multicycle_control_if #(.CNT_W(4))  bus_a ();
    multicycle_control_if #(.CNT_W(32)) bus_b ();

    multicycle_control #(.CNT_W(4), .ILLEGAL_HALT(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
    );
    multicycle_control #(.CNT_W(32), .ILLEGAL_HALT(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b)
    );

    assign bus_a.run = run;
    assign bus_a.opcode = opcode;
    assign bus_a.funct7 = funct7;
    assign bus_a.zero = zero;
    assign bus_b.run = run;
    assign bus_b.opcode = opcode;
    assign bus_b.funct7 = funct7;
    assign bus_b.zero = zero;
`ifdef MULTICYCLE_CONTROL_MEM_WAIT_EN
    assign bus_a.mem_ready = mem_ready;
    assign bus_b.mem_ready = mem_ready;
`endif

    // 0 lw, 1 sw, 2 R-type, 3 beq, 4 illegal
    function automatic int cls(input logic [6:0] op, input logic [6:0] f7);
        if (op == 7'b0000011) return 0;
        if (op == 7'b0100011) return 1;
        if (op == 7'b0110011 && (f7 == 7'h00 || f7 == 7'h20)) return 2;
        if (op == 7'b1100011) return 3;
        return 4;
    endfunction

    function automatic logic [15:0] outs_a();
        return {bus_a.aluop, bus_a.alu_src_a, bus_a.alu_src_b, bus_a.result_src, bus_a.adr_src,
                bus_a.ir_write, bus_a.mem_write, bus_a.reg_write, bus_a.pc_write, bus_a.illegal,
                2'b00};
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        exp_ret = 0;
    endtask

    // Runs one instruction from FETCH until the next FETCH, checking it against the class model.
    task automatic do_instr(input logic [6:0] op, input logic [6:0] f7, input logic z);
        int c, lat, nreg, nmem, npc, nill, reg_cyc;
        logic [1:0] rs_reg;
        logic [5:0] dec_sel, ex_sel, exp_ex;
        logic [9:0] fetch_v;
        int exp_lat [5] = '{5, 4, 4, 3, 0};
        opcode = op; funct7 = f7; zero = z;
        #1;
        c = cls(op, f7);
        lat = 0; nreg = 0; nmem = 0; npc = 0; nill = 0; reg_cyc = 0; rs_reg = 2'b11;
        dec_sel = '1; ex_sel = '1; fetch_v = '0;
        for (int k = 1; k <= 12; k++) begin
            if (k > 1 && bus_a.ir_write === 1'b1) begin
                lat = k - 1;
                break;
            end
            if (k == 1) fetch_v = {bus_a.adr_src, bus_a.ir_write, bus_a.pc_write, bus_a.aluop,
                                   bus_a.alu_src_a, bus_a.alu_src_b, bus_a.result_src[1]};
            if (k == 2) dec_sel = {bus_a.aluop, bus_a.alu_src_a, bus_a.alu_src_b};
            if (k == 3) ex_sel = {bus_a.aluop, bus_a.alu_src_a, bus_a.alu_src_b};
            if (k > 1) begin
                if (bus_a.reg_write === 1'b1) begin
                    nreg++; reg_cyc = k; rs_reg = bus_a.result_src;
                end
                nmem += int'(bus_a.mem_write === 1'b1);
                npc  += int'(bus_a.pc_write === 1'b1);
                nill += int'(bus_a.illegal === 1'b1);
            end
            step();
        end
        total_mem += nmem;
        if (c != 4) exp_ret++;
        exp_ex = (c == 2) ? 6'b10_10_00 : (c == 3) ? 6'b01_10_00 : 6'b00_10_01;

        checks++;
        if (fetch_v !== 10'b0_1_1_00_00_10_1) begin
            errors++; $display("FAIL fetch_outputs op=%b got %b exp %b", op, fetch_v, 10'b0110000101);
        end
        checks++;
        if (lat != exp_lat[c]) begin
            errors++; $display("FAIL latency op=%b got %0d exp %0d", op, lat, exp_lat[c]);
        end
        checks++;
        if (dec_sel !== 6'b00_01_01) begin
            errors++; $display("FAIL decode_sel op=%b got %b exp 000101", op, dec_sel);
        end
        checks++;
        if (ex_sel !== exp_ex) begin
            errors++; $display("FAIL exec_sel op=%b got %b exp %b", op, ex_sel, exp_ex);
        end
        checks++;
        if (nreg != ((c == 0 || c == 2) ? 1 : 0)) begin
            errors++; $display("FAIL reg_write_count op=%b got %0d", op, nreg);
        end
        if (c == 0 || c == 2) begin
            checks++;
            if (reg_cyc != lat || rs_reg !== ((c == 0) ? 2'b01 : 2'b00)) begin
                errors++; $display("FAIL reg_write_cycle op=%b got cyc %0d rs %b exp cyc %0d",
                                   op, reg_cyc, rs_reg, lat);
            end
        end
        checks++;
        if (nmem != ((c == 1) ? 1 : 0)) begin
            errors++; $display("FAIL mem_write_count op=%b got %0d", op, nmem);
        end
        checks++;
        if (npc != ((c == 3 && z) ? 1 : 0)) begin
            errors++; $display("FAIL branch_pc_write op=%b z=%b got %0d", op, z, npc);
        end
        checks++;
        if (nill != 0) begin
            errors++; $display("FAIL illegal_seen op=%b got %0d exp 0", op, nill);
        end
        checks++;
        if (bus_a.instret !== 4'(exp_ret) || bus_b.instret !== 32'(exp_ret)) begin
            errors++; $display("FAIL instret got %0d/%0d exp %0d", bus_a.instret, bus_b.instret,
                               exp_ret);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b1; opcode = '0; funct7 = '0; zero = 1'b0; mem_ready = 1'b1;
        #12;
        checks++;
        if (outs_a() !== 16'h0 || bus_a.instret !== 4'd0 || bus_b.instret !== 32'd0) begin
            errors++; $display("FAIL reset_outputs got %h instret %0d exp 0", outs_a(), bus_a.instret);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus_a.ir_write !== 1'b1) begin
            errors++; $display("FAIL reset_to_fetch ir_write got %b exp 1", bus_a.ir_write);
        end
    endtask

    task automatic test_lw_rtype_beq();
        do_instr(7'b0000011, 7'h00, 1'b0);
        do_instr(7'b0110011, 7'h20, 1'b0);
        do_instr(7'b0110011, 7'h00, 1'b1);
        do_instr(7'b1100011, 7'h00, 1'b1);
        do_instr(7'b1100011, 7'h00, 1'b0);
        do_instr(7'b0100011, 7'h00, 1'b1);
    endtask

    task automatic test_reset_mid_memrd();
        opcode = 7'b0000011; funct7 = '0;
        #1;
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (bus_a.adr_src !== 1'b1 || bus_a.reg_write !== 1'b0) begin
            errors++; $display("FAIL in_memrd adr_src got %b exp 1", bus_a.adr_src);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (outs_a() !== 16'h0 || bus_a.instret !== 4'd0 || bus_b.instret !== 32'd0) begin
            errors++; $display("FAIL reset_mid_memrd got %h instret %0d exp 0", outs_a(), bus_a.instret);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        exp_ret = 0;
        checks++;
        if (bus_a.ir_write !== 1'b1 || bus_a.reg_write !== 1'b0) begin
            errors++; $display("FAIL fetch_after_reset ir_write got %b exp 1", bus_a.ir_write);
        end
    endtask

    task automatic test_run_gate();
        int nir, nmem;
        run = 1'b0;
        #1;
        nir = 0;
        for (int i = 0; i < 3; i++) begin
            nir += int'(outs_a() !== 16'h0);
            step();
        end
        checks++;
        if (nir != 0) begin
            errors++; $display("FAIL run_low_idle got %0d active cycles exp 0", nir);
        end
        opcode = 7'b0100011; run = 1'b1;
        #1;
        step();
        run = 1'b0;
        nir = 0; nmem = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            nir  += int'(bus_a.ir_write === 1'b1);
            nmem += int'(bus_a.mem_write === 1'b1);
            step();
        end
        exp_ret++;
        checks++;
        if (nir != 0 || nmem != 1 || bus_b.instret !== 32'(exp_ret)) begin
            errors++; $display("FAIL inflight_complete got ir %0d mem %0d ret %0d exp 0 1 %0d",
                               nir, nmem, bus_b.instret, exp_ret);
        end
        run = 1'b1;
        #1;
    endtask

    task automatic test_trap();
        logic [6:0] ops [2] = '{7'b0110011, 7'b1111111};
        for (int t = 0; t < 2; t++) begin
            do_reset();
            opcode = ops[t]; funct7 = 7'b0000001;
            #1;
            step(); step();
            checks++;
            if (bus_a.illegal !== 1'b1 || bus_b.illegal !== 1'b1 ||
                {bus_a.ir_write, bus_a.mem_write, bus_a.reg_write, bus_a.pc_write} !== 4'b0) begin
                errors++; $display("FAIL trap_enter op=%b got ill %b/%b", ops[t], bus_a.illegal,
                                   bus_b.illegal);
            end
            step();
            checks++;
            if (bus_a.illegal !== 1'b1 || bus_b.illegal !== 1'b0 || bus_b.ir_write !== 1'b1) begin
                errors++; $display("FAIL trap_exit op=%b got haltA %b B ill %b ir %b exp 1 0 1",
                                   ops[t], bus_a.illegal, bus_b.illegal, bus_b.ir_write);
            end
            step(); step(); step();
            checks++;
            if (bus_a.illegal !== 1'b1 || bus_a.instret !== 4'd0 || bus_b.instret !== 32'd0) begin
                errors++; $display("FAIL trap_hold got ill %b instret %0d exp 1 0", bus_a.illegal,
                                   bus_a.instret);
            end
        end
        do_reset();
    endtask

    task automatic test_wrap();
        do_reset();
        total_mem = 0;
        for (int i = 0; i < 16; i++) do_instr(7'b0100011, 7'($urandom), 1'($urandom));
        checks++;
        if (total_mem != 16 || bus_a.instret !== 4'd0 || bus_b.instret !== 32'd16) begin
            errors++; $display("FAIL wrap got mem %0d instret %0d/%0d exp 16 0 16", total_mem,
                               bus_a.instret, bus_b.instret);
        end
    endtask

    task automatic test_random();
        logic [6:0] ops [4] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b1100011};
        for (int i = 0; i < 40; i++) begin
            int c;
            logic [6:0] f7;
            c = int'($urandom_range(0, 3));
            f7 = (c == 2) ? (($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00) : 7'($urandom);
            do_instr(ops[c], f7, 1'($urandom));
        end
    endtask

`ifdef MULTICYCLE_CONTROL_MEM_WAIT_EN
    task automatic test_mem_wait();
        int nmem;
        int start_ret;
        do_reset();
        start_ret = exp_ret;
        opcode = 7'b0100011; mem_ready = 1'b0;
        #1;
        step();
        checks++;
        if (bus_a.ir_write !== 1'b1) begin
            errors++; $display("FAIL fetch_hold ir_write got %b exp 1", bus_a.ir_write);
        end
        mem_ready = 1'b1;
        step(); step();
        mem_ready = 1'b0;
        step();
        nmem = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                checks++;
                if (bus_a.instret !== 4'(start_ret)) begin
                    errors++; $display("FAIL stall_instret got %0d exp %0d", bus_a.instret, start_ret);
                end
                mem_ready = 1'b1;
                #1;
            end
            nmem += int'(bus_a.mem_write === 1'b1);
            if (i < 3) step();
        end
        step();
        exp_ret = start_ret + 1;
        checks++;
        if (nmem != 4 || bus_a.ir_write !== 1'b1 || bus_b.instret !== 32'(exp_ret)) begin
            errors++; $display("FAIL mem_wait got mem %0d ir %b ret %0d exp 4 1 %0d", nmem,
                               bus_a.ir_write, bus_b.instret, exp_ret);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_lw_rtype_beq();
        test_reset_mid_memrd();
        test_run_gate();
        test_trap();
        test_wrap();
        test_random();
`ifdef MULTICYCLE_CONTROL_MEM_WAIT_EN
        test_mem_wait();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
